// File: rtl/versatile_fifo_sync_fwft_ctrl_pkg.sv
// Shared constants and the pointer-width helper for the FWFT FIFO controller.
// Pointers carry one extra bit so a full FIFO and an empty FIFO have different encodings.
package versatile_fifo_sync_fwft_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 11;

  function automatic int ptrWidth(input int addrWidth);
    return addrWidth + 1;
  endfunction

endpackage

// File: rtl/versatile_fifo_sync_fwft_ctrl_ptr_cnt.sv
// Wrapping pointer counter with enable and synchronous reset.
// It is used for both the write pointer and the read pointer.
module versatile_fifo_ptr_cnt #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = en_i ? value_q + WIDTH'(1) : value_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/versatile_fifo_sync_fwft_ctrl.sv
// First-word-fall-through FIFO controller driving an external RAM that has one cycle of read latency.
// Full and almost_full use the live write pointer. Empty and count use the write pointer delayed by one cycle, which covers the RAM latency.
module versatile_fifo_sync_fwft_ctrl
  import versatile_fifo_sync_fwft_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic                  ram_we_a,
  output logic [DATA_WIDTH-1:0] ram_d_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int PW = ptrWidth(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         wptrLag_q;
  logic [PW-1:0]         wrLevel;
  logic [ADDR_WIDTH-1:0] rdAdrNext;
  logic                  wrFire;
  logic                  rdFire;
  logic                  overflow_q;
  logic                  underflow_q;

  assign wrLevel     = wptr - rptr;
  assign full        = (wrLevel == DEPTH);
  assign almost_full = (wrLevel >= PW'(AFULL_LEVEL));
  assign empty       = (rptr == wptrLag_q);
  assign count       = wptrLag_q - rptr;

  // Reset wins over both request inputs, so nothing reaches the RAM while it is asserted.
  assign wrFire = wr_en & ~full & ~rst;
  assign rdFire = rd_en & ~empty & ~rst;

  assign ram_we_a  = wrFire;
  assign ram_adr_a = wptr[ADDR_WIDTH-1:0];
  assign ram_d_a   = wr_data;

  // Look one entry ahead on a read so that the RAM output register holds the new head after the edge.
  assign rdAdrNext = rptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
  assign ram_adr_b = rdFire ? rdAdrNext : rptr[ADDR_WIDTH-1:0];
  assign rd_data   = ram_q_b;

  versatile_fifo_ptr_cnt #(.WIDTH(PW)) wptrCnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (wrFire),
    .value_o(wptr)
  );

  versatile_fifo_ptr_cnt #(.WIDTH(PW)) rptrCnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (rdFire),
    .value_o(rptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptrLag_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptrLag_q   <= wptr;
      overflow_q  <= wr_en & full;
      underflow_q <= rd_en & empty;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/versatile_fifo_sync_fwft_ctrl.md
VERSATILE_FIFO_SYNC_FWFT_CTRL -- requirements
Module: versatile_fifo_sync_fwft_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the entry width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, giving RAM depth 2**ADDR_WIDTH.
REQ-003 SHALL have parameter AFULL_LEVEL, default 2**ADDR_WIDTH-2, the almost_full threshold.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  write request.
REQ-008 wr_data  in  DATA_WIDTH  write data.
REQ-009 full  out  1  no free RAM entry.
REQ-010 almost_full  out  1  write-side entries >= AFULL_LEVEL.
REQ-011 rd_en  in  1  consume head entry.
REQ-012 rd_data  out  DATA_WIDTH  head entry, first-word-fall-through; equals ram_q_b.
REQ-013 empty  out  1  no visible entry; rd_data invalid.
REQ-014 count  out  ADDR_WIDTH+1  visible entries.
REQ-015 overflow / underflow  out  1 each  registered one-cycle error pulses.
REQ-016 ram_adr_a, ram_we_a, ram_d_a  out  ADDR_WIDTH, 1, DATA_WIDTH  RAM write port.
REQ-017 ram_adr_b  out  ADDR_WIDTH  RAM read address; ram_q_b  in  DATA_WIDTH  registered RAM read data, one-cycle latency.

Function
REQ-018 SHALL keep wptr and rptr, each ADDR_WIDTH+1 bits, wrapping modulo 2**(ADDR_WIDTH+1); RAM addresses SHALL be the low ADDR_WIDTH bits.
REQ-019 SHALL keep wptr_q, a copy of wptr delayed one clock.
REQ-020 SHALL set full = ((wptr - rptr) == 2**ADDR_WIDTH), combinational from registers.
REQ-021 SHALL set almost_full = ((wptr - rptr) >= AFULL_LEVEL).
REQ-022 SHALL set wr_fire = wr_en & ~full; ram_we_a = wr_fire; ram_adr_a = wptr low bits; ram_d_a = wr_data; wptr increments by 1 on wr_fire.
REQ-023 SHALL set empty = (rptr == wptr_q) and count = wptr_q - rptr.
REQ-024 SHALL set rd_fire = rd_en & ~empty; rptr increments by 1 on rd_fire.
REQ-025 SHALL drive ram_adr_b = low bits of (rd_fire ? rptr+1 : rptr) so that ram_q_b always holds the head entry after the edge.
REQ-026 Write-to-visible latency SHALL be 2 edges: for wr_en sampled at edge e into an empty FIFO, empty deasserts after edge e+1 with rd_data valid.
REQ-027 Read SHALL take effect at the sampling edge; the next entry, if visible, SHALL appear on rd_data after that same edge (back-to-back reads at full rate).
REQ-028 When full, wr_en SHALL be ignored even if rd_fire occurs in the same cycle; overflow SHALL pulse high the following cycle.
REQ-029 When empty, rd_en SHALL be ignored even if wr_fire occurs in the same cycle; underflow SHALL pulse high the following cycle.
REQ-030 Simultaneous wr_fire and rd_fire SHALL leave wptr - rptr unchanged.
REQ-031 Pointer wrap past 2**ADDR_WIDTH SHALL not disturb full/empty/count.

Reset
REQ-032 On rst high at an edge: wptr, rptr, wptr_q = 0; empty = 1; full = 0; almost_full = 0; count = 0; overflow = underflow = 0.
REQ-033 rst SHALL take priority over wr_en and rd_en; reset mid-operation SHALL discard all contents; RAM contents are not cleared.
REQ-034 ram_we_a SHALL be 0 while rst is high.

Structure
REQ-035 A shared package SHALL hold the pointer width function (ADDR_WIDTH+1) and the default DATA_WIDTH/ADDR_WIDTH constants.
REQ-036 One sub-module, versatile_fifo_ptr_cnt (ADDR_WIDTH+1-bit wrapping counter with enable and sync reset), SHALL be instantiated for wptr and rptr.
REQ-037 The RAM SHALL be external; this block has no storage array.

Verification (ADDR_WIDTH=2, depth 4, AFULL_LEVEL=3)
REQ-038 Reset, write 0xA5 at edge 1 -> empty=0, rd_data=0xA5, count=1 after edge 2.
REQ-039 Write 0x01..0x04 back-to-back -> full=1 after 4th write, almost_full=1 after 3rd; 5th write -> ignored, overflow pulse.
REQ-040 FIFO full, rd_en=1 and wr_en=1 same cycle -> read of 0x01 accepted, write rejected, overflow pulse, count=3.
REQ-041 Empty, rd_en=1 -> underflow pulse, pointers unchanged; continuous write+read of 12 words -> in-order data across two pointer wraps.
REQ-042 Fill 3 entries, assert rst mid-stream -> empty=1, count=0, next write 0x5A reads back 0x5A.
